// File: rtl/arith18_pkg.sv
// Shared width and operand/result types for the 18-bit subtractor and its arbiter.
// Pure declarations; no logic, no latency, no backpressure.
package arith18_pkg;

  localparam int ARITH_W = 18;

  typedef logic [ARITH_W-1:0] op_t;

  typedef struct packed {
    logic borrow;
    op_t  diff;
  } sub_res_t;

endpackage

// File: rtl/arith18_sub_arbiter_if.sv
// Request/result bundle between requesting units and the shared-subtractor arbiter.
// master = requesters + result consumer, slave = arbiter.
interface arith18_sub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import arith18_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*ARITH_W-1:0] req_op1;
  logic [NUM_REQ*ARITH_W-1:0] req_op2;
  logic                       res_valid;
  logic                       res_ready;
  op_t                        res_diff;
  logic                       res_borrow;
  logic [ID_W-1:0]            res_id;

  modport master (
    output req_valid, req_op1, req_op2, res_ready,
    input  req_ready, res_valid, res_diff, res_borrow, res_id
  );

  modport slave (
    input  req_valid, req_op1, req_op2, res_ready,
    output req_ready, res_valid, res_diff, res_borrow, res_id
  );

endinterface

// File: rtl/arith18_rr_arb.sv
// Round-robin picker: first asserted req at or after ptr, wrapping; one-hot grant plus index.
// Combinational, zero latency; grant is forced to zero when en is low.
module arith18_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = ID_W'(cand);
      end
    end
    if (en && found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/arith18_sub.sv
// Unsigned 18-bit subtractor: diff = op1 - op2 mod 2^18, borrow = op1 < op2.
// Purely combinational, zero latency, no backpressure.
module arith18_sub
  import arith18_pkg::*;
(
  input  op_t  op1,
  input  op_t  op2,
  output op_t  diff,
  output logic borrow
);

  sub_res_t res;

  // One extra bit on the left catches the borrow out of the MSB.
  assign res    = {1'b0, op1} - {1'b0, op2};
  assign diff   = res.diff;
  assign borrow = res.borrow;

endmodule

// File: rtl/arith18_sub_arbiter.sv
// Shares one 18-bit subtractor among NUM_REQ requesters, round-robin, one result register.
// Result visible one edge after accept; requests stall only while a result is held and res_ready is low.
module arith18_sub_arbiter
  import arith18_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  arith18_sub_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  op_t                diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic               can_accept;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               xfer;
  op_t                op1_sel, op2_sel;
  op_t                sub_diff;
  logic               sub_borrow;

  assign can_accept = (state_q == ST_EMPTY) || bus.res_ready;
  // rst_n gate keeps req_ready low during reset even though the empty register would accept.
  assign arb_en     = can_accept && rst_n;

  arith18_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (gnt_idx)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;
  assign op1_sel       = bus.req_op1[gnt_idx*ARITH_W +: ARITH_W];
  assign op2_sel       = bus.req_op2[gnt_idx*ARITH_W +: ARITH_W];

  arith18_sub u_sub (
    .op1    (op1_sel),
    .op2    (op2_sel),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  always_comb begin
    state_d  = state_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d  = ST_FULL;
      diff_d   = sub_diff;
      borrow_d = sub_borrow;
      id_d     = gnt_idx;
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (bus.res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.res_valid  = (state_q == ST_FULL);
  assign bus.res_diff   = diff_q;
  assign bus.res_borrow = borrow_q;
  assign bus.res_id     = id_q;

endmodule

// File: tb/tb_arith18_sub_arbiter.sv
// Directed table-driven bench for arith18_sub_arbiter plus backpressure, reset and round-robin sequences.
module tb_arith18_sub_arbiter;
  import arith18_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam logic [17:0] FILL1 = 18'h3F0F0;
  localparam logic [17:0] FILL2 = 18'h00F0F;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  arith18_sub_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  arith18_sub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  rv;
    int          lane;
    logic [17:0] op1;
    logic [17:0] op2;
    logic        rr;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [17:0] e_diff;
    logic        e_bor;
    logic [1:0]  e_id;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Operands go on one lane; other lanes carry filler so a wrong mux select shows up in diff.
  task automatic drive(input logic [3:0] rv, input int lane, input logic [17:0] op1,
                       input logic [17:0] op2, input logic rr);
    bus.req_valid = rv;
    bus.res_ready = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_op1[i*18 +: 18] = (i == lane) ? op1 : FILL1;
      bus.req_op2[i*18 +: 18] = (i == lane) ? op2 : FILL2;
    end
  endtask

  task automatic chk_res(input string tag, input logic vld, input logic [17:0] diff,
                         input logic bor, input logic [1:0] id);
    chk({tag, ".res_valid"},  32'(bus.res_valid),  32'(vld));
    chk({tag, ".res_diff"},   32'(bus.res_diff),   32'(diff));
    chk({tag, ".res_borrow"}, 32'(bus.res_borrow), 32'(bor));
    chk({tag, ".res_id"},     32'(bus.res_id),     32'(id));
  endtask

  initial begin
    //          rv     lane op1       op2       rr    e_rdy   vld  diff      bor  id
    vt[0]  = '{4'b0000, 0, 18'h00000, 18'h00000, 1'b1, 4'b0000, 1'b0, 18'h00000, 1'b0, 2'd0};
    vt[1]  = '{4'b0100, 2, 18'h00010, 18'h00003, 1'b1, 4'b0100, 1'b1, 18'h0000D, 1'b0, 2'd2};
    vt[2]  = '{4'b0100, 2, 18'h00000, 18'h00001, 1'b1, 4'b0100, 1'b1, 18'h3FFFF, 1'b1, 2'd2};
    vt[3]  = '{4'b0010, 1, 18'h2AAAA, 18'h2AAAA, 1'b1, 4'b0010, 1'b1, 18'h00000, 1'b0, 2'd1};
    vt[4]  = '{4'b1111, 2, 18'h00100, 18'h00001, 1'b1, 4'b0100, 1'b1, 18'h000FF, 1'b0, 2'd2};
    vt[5]  = '{4'b1111, 3, 18'h20000, 18'h1FFFF, 1'b1, 4'b1000, 1'b1, 18'h00001, 1'b0, 2'd3};
    vt[6]  = '{4'b1111, 0, 18'h00005, 18'h00009, 1'b1, 4'b0001, 1'b1, 18'h3FFFC, 1'b1, 2'd0};
    vt[7]  = '{4'b1111, 1, 18'h12345, 18'h02345, 1'b1, 4'b0010, 1'b1, 18'h10000, 1'b0, 2'd1};
    vt[8]  = '{4'b0000, 0, 18'h00000, 18'h00000, 1'b1, 4'b0000, 1'b0, 18'h10000, 1'b0, 2'd1};
    vt[9]  = '{4'b1001, 3, 18'h00001, 18'h00002, 1'b0, 4'b1000, 1'b1, 18'h3FFFF, 1'b1, 2'd3};
    vt[10] = '{4'b1111, 0, 18'h00007, 18'h00001, 1'b0, 4'b0000, 1'b1, 18'h3FFFF, 1'b1, 2'd3};
    vt[11] = '{4'b0011, 0, 18'h3FFFF, 18'h00000, 1'b1, 4'b0001, 1'b1, 18'h3FFFF, 1'b0, 2'd0};
    vt[12] = '{4'b0001, 0, 18'h00000, 18'h3FFFF, 1'b1, 4'b0001, 1'b1, 18'h00001, 1'b1, 2'd0};
    vt[13] = '{4'b0000, 0, 18'h00000, 18'h00000, 1'b1, 4'b0000, 1'b0, 18'h00001, 1'b1, 2'd0};

    // Reset with requests pending: nothing may be granted.
    rst_n = 1'b0;
    drive(4'b1111, 0, 18'h00001, 18'h00001, 1'b1);
    #12;
    chk("reset.req_ready", 32'(bus.req_ready), 32'h0);
    chk_res("reset", 1'b0, 18'h0, 1'b0, 2'd0);
    drive(4'b0000, 0, 18'h0, 18'h0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 14; v++) begin
      drive(vt[v].rv, vt[v].lane, vt[v].op1, vt[v].op2, vt[v].rr);
      #1;
      chk($sformatf("vec%0d.req_ready", v), 32'(bus.req_ready), 32'(vt[v].e_rdy));
      @(posedge clk);
      #1;
      chk_res($sformatf("vec%0d", v), vt[v].e_vld, vt[v].e_diff, vt[v].e_bor, vt[v].e_id);
    end

    // Backpressure: fill with lane 1 (ptr is 1), hold for 5 cycles, then release.
    drive(4'b0010, 1, 18'h00020, 18'h00008, 1'b0);
    @(posedge clk);
    #1;
    chk_res("bp_fill", 1'b1, 18'h00018, 1'b0, 2'd1);
    drive(4'b1111, 0, 18'h00033, 18'h00011, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_hold%0d.req_ready", c), 32'(bus.req_ready), 32'h0);
      @(posedge clk);
      #1;
      chk_res($sformatf("bp_hold%0d", c), 1'b1, 18'h00018, 1'b0, 2'd1);
    end
    drive(4'b0010, 1, 18'h00007, 18'h00003, 1'b1);
    #1;
    chk("bp_release.req_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk);
    #1;
    chk_res("bp_release", 1'b1, 18'h00004, 1'b0, 2'd1);

    // Reset while FULL discards the result asynchronously; ptr returns to 0.
    drive(4'b1111, 3, 18'h00009, 18'h00001, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset.res_valid", 32'(bus.res_valid), 32'h0);
    chk("mid_reset.res_diff",  32'(bus.res_diff),  32'h0);
    chk("mid_reset.req_ready", 32'(bus.req_ready), 32'h0);
    #1;
    rst_n = 1'b1;

    // All four valid with res_ready high: grants 0,1,2,3,0 with no bubble.
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_op1[i*18 +: 18] = 18'(i * 'h100 + 'h50);
      bus.req_op2[i*18 +: 18] = 18'h00010;
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr%0d.req_ready", k), 32'(bus.req_ready), 32'(1 << (k % NUM_REQ)));
      @(posedge clk);
      #1;
      chk_res($sformatf("rr%0d", k), 1'b1, 18'((k % NUM_REQ) * 'h100 + 'h40), 1'b0,
              2'(k % NUM_REQ));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
